serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Sequencer that performs WIDTH-bit two's-complement add/subtract bit-serially through a single shared 1-bit full adder, LSB first, one bit per clock. It sits between the processor's operand source and result sink. Both sides use a valid/ready handshake. It trades WIDTH cycles of latency for one-bit adder area.

## Interface
- WIDTH, 8, operand/result width in bits; legal values are ≥2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and op are presented.
- in_ready  out  1  block accepts operands (high only in IDLE).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 selects A+B; 1 selects A−B.
- out_valid  out  1  result, cout and ovf are valid (high only in DONE).
- out_ready  in  1  sink accepts the result.
- result  out  WIDTH  sum or difference.
- cout  out  1  carry out of the MSB. For subtract, 1 means no borrow.
- ovf  out  1  signed overflow.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready:
    - latch a into shift reg sa, and b^{WIDTH{sub}} into sb;
    - set carry reg c=sub;
    - set bit counter cnt=0;
    - go to RUN.
- **RUN**
  - The shared full adder takes sa[0], sb[0], c.
  - Each cycle:
    - shift the sum bit into result from the MSB side (result <= {s, result[WIDTH-1:1]});
    - shift sa and sb right by 1;
    - set c <= adder carry;
    - increment cnt.
  - When cnt==WIDTH-2, register the adder carry-in of the next (MSB) bit as c_msb.
  - On the cycle cnt==WIDTH-1:
    - set cout <= adder carry;
    - set ovf <= c ^ adder carry (carry into MSB xor carry out);
    - go to DONE.
- **DONE**
  - out_valid=1; result, cout and ovf are held stable.
  - When out_ready=1, go to IDLE.
  - When out_ready=0, stay in DONE indefinitely (backpressure).
- Inputs a, b and sub are sampled only at the accept edge. Changes afterwards have no effect.
- in_valid is ignored outside IDLE. There is no queuing or bypass: in DONE with out_ready=1, in_ready is still 0 that cycle.
- All arithmetic is modulo 2^WIDTH. cnt is $clog2(WIDTH) bits wide and wraps only via the reset-to-0 at accept.

## Timing
- **Reset (async, immediate)**
  - state=IDLE; result=0, cout=0, ovf=0, c=0, cnt=0, sa=0, sb=0.
  - out_valid=0, in_ready=1.
- **Latency:** the accept edge is edge 0. RUN spans edges 1..WIDTH. out_valid rises after edge WIDTH, i.e. WIDTH cycles after accept.
- **Throughput:** with out_ready tied high, one operation every WIDTH+2 cycles.
- **Reset mid-RUN or mid-DONE:** the operation is aborted and outputs return to reset values. No stale out_valid appears. The first post-reset operation completes correctly.
- in_ready and out_valid are decoded purely from the state register, with no combinational path from in_valid or out_ready.

## Structure
- Shared package holds:
  - state encoding constants IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - the default WIDTH constant.
- One sub-module: the team's existing 1-bit full adder `fa`, instantiated exactly once. The sequencer contains no other adder logic.
- Datapath registers are sa, sb, result, c, cnt, cout and ovf. Everything else is the FSM.

## Test plan
- Add 0x5A+0x33 (sub=0) -> result=0x8D, cout=0, ovf=1; out_valid rises exactly 8 cycles after accept.
- Subtract 0x10−0x20 -> result=0xF0, cout=0 (borrow), ovf=0. Subtract 0x20−0x10 -> result=0x10, cout=1, ovf=0.
- Add 0xFF+0x01 -> result=0x00, cout=1, ovf=0. Add 0x7F+0x01 -> result=0x80, cout=0, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and a/b.
  - result, cout and ovf stay stable; in_ready stays 0.
  - After out_ready=1: IDLE next cycle, and a new op of 0x01+0x01 -> 0x02.
- Assert rst asynchronously mid-RUN (cnt=4) of 0x5A+0x33.
  - Outputs go to 0 immediately; out_valid=0, in_ready=1.
  - A following op of 0x80−0x01 -> result=0x7F, cout=1, ovf=1.
- Back-to-back ops with in_valid and out_ready held high:
  - accepts are spaced exactly WIDTH+2 cycles apart;
  - in_valid never triggers an accept outside IDLE.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// rtl/serial_add_ctrl_pkg.sv - shared state encoding and default width for serial_add_ctrl
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/fa.sv
// rtl/fa.sv - 1-bit full adder
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial WIDTH-bit add/subtract sequencer around one shared full adder
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MSB = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(WIDTH - 2);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             c;
  logic             c_msb;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_co;

  fa u_fa (
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (c),
    .s  (fa_s),
    .co (fa_co)
  );

  // Handshake flags come straight from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      c      <= 1'b0;
      c_msb  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
            sa    <= a;
            sb    <= b ^ {WIDTH{sub}};
            c     <= sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          result <= {fa_s, result[WIDTH-1:1]};
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          c      <= fa_co;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_PRE) begin
            c_msb <= fa_co;
          end
          if (cnt == CNT_MSB) begin
            cout  <= fa_co;
            ovf   <= c_msb ^ fa_co;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - randomized self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int n_checks = 0;
  int n_fail   = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, overflow judged by signed range.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    int xs, ys, sres, ux, uy;
    logic [W-1:0] r;
    logic co, ov;
    xs = int'($signed(x));
    ys = int'($signed(y));
    ux = int'(x);
    uy = int'(y);
    sres = s ? xs - ys : xs + ys;
    ov = (sres > 127) || (sres < -128);
    co = s ? (ux >= uy) : ((ux + uy) > 255);
    r = s ? W'(ux - uy) : W'(ux + uy);
    return {ov, co, r};
  endfunction

  // Runs one operation starting just after a clock edge with the DUT idle.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs,
                        output logic [W-1:0] r, output logic co, output logic ov,
                        output int lat, output logic rdy);
    a = xa; b = xb; sub = xs; in_valid = 1'b1;
    rdy = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result; co = cout; ov = ovf;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid, result, cout, ovf} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state got rdy=%b vld=%b res=%h co=%b ov=%b required 1 0 00 0 0",
               in_ready, out_valid, result, cout, ovf);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] va [6] = '{8'h5A, 8'h10, 8'h20, 8'hFF, 8'h7F, 8'h80};
    logic [W-1:0] vb [6] = '{8'h33, 8'h20, 8'h10, 8'h01, 8'h01, 8'h01};
    logic         vs [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] er [6] = '{8'h8D, 8'hF0, 8'h10, 8'h00, 8'h80, 8'h7F};
    logic         ec [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic         eo [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] r;
    logic co, ov, rdy;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], vs[i], r, co, ov, lat, rdy);
      n_checks++;
      if ({r, co, ov} !== {er[i], ec[i], eo[i]}) begin
        n_fail++;
        $display("FAIL directed_%0d got res=%h co=%b ov=%b required res=%h co=%b ov=%b",
                 i, r, co, ov, er[i], ec[i], eo[i]);
      end
      n_checks++;
      if (lat !== W || rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL directed_latency_%0d got lat=%0d rdy=%b required lat=%0d rdy=1", i, lat, rdy, W);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] xa, xb, r;
    logic xs, co, ov, rdy;
    logic [W+1:0] exp;
    int lat;
    for (int i = 0; i < 30; i++) begin
      xa = W'($urandom); xb = W'($urandom); xs = 1'($urandom);
      exp = model(xa, xb, xs);
      run_op(xa, xb, xs, r, co, ov, lat, rdy);
      n_checks++;
      if ({ov, co, r} !== exp || lat !== W) begin
        n_fail++;
        $display("FAIL random_%0d a=%h b=%h sub=%b got res=%h co=%b ov=%b lat=%0d required res=%h co=%b ov=%b lat=%0d",
                 i, xa, xb, xs, r, co, ov, lat, exp[W-1:0], exp[W], exp[W+1], W);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W+1:0] exp;
    logic [W-1:0] r;
    logic co, ov, rdy;
    int lat;
    exp = model(8'h33, 8'h44, 1'b0);
    a = 8'h33; b = 8'h44; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (!out_valid) begin
      n_fail++;
      $display("FAIL bp_wait_done got out_valid=0 required 1");
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid; a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if ({ovf, cout, result} !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold_%0d got res=%h co=%b ov=%b rdy=%b vld=%b required res=%h co=%b ov=%b rdy=0 vld=1",
                 i, result, cout, ovf, in_ready, out_valid, exp[W-1:0], exp[W], exp[W+1]);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release got rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
    end
    run_op(8'h01, 8'h01, 1'b0, r, co, ov, lat, rdy);
    n_checks++;
    if (r !== 8'h02 || lat !== W) begin
      n_fail++;
      $display("FAIL bp_next_op got res=%h lat=%0d required res=02 lat=%0d", r, lat, W);
    end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    logic [W+1:0] expq[$];
    logic [W+1:0] e;
    int guard;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        n_checks++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_spurious_out got out_valid=1 required no pending op");
        end else begin
          e = expq.pop_front();
          if ({ovf, cout, result} !== e) begin
            n_fail++;
            $display("FAIL b2b_result got res=%h co=%b ov=%b required res=%h co=%b ov=%b",
                     result, cout, ovf, e[W-1:0], e[W], e[W+1]);
          end
        end
      end
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      if (in_ready) begin
        acc.push_back(cyc);
        expq.push_back(model(a, b, sub));
      end
    end
    n_checks++;
    if (acc.size() < 5) begin
      n_fail++;
      $display("FAIL b2b_accept_count got %0d required at least 5", acc.size());
    end
    for (int i = 1; i < acc.size(); i++) begin
      n_checks++;
      if (acc[i] - acc[i-1] !== W + 2) begin
        n_fail++;
        $display("FAIL b2b_spacing_%0d got %0d required %0d", i, acc[i] - acc[i-1], W + 2);
      end
    end
    in_valid = 1'b0;
    guard = 0;
    while (!in_ready && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL b2b_drain got in_ready=0 required 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] r;
    logic co, ov, rdy;
    int lat;
    a = 8'h5A; b = 8'h33; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid, result, cout, ovf} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_run got rdy=%b vld=%b res=%h co=%b ov=%b required 1 0 00 0 0",
               in_ready, out_valid, result, cout, ovf);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(8'h80, 8'h01, 1'b1, r, co, ov, lat, rdy);
    n_checks++;
    if ({r, co, ov} !== {8'h7F, 1'b1, 1'b1} || lat !== W) begin
      n_fail++;
      $display("FAIL post_reset_op got res=%h co=%b ov=%b lat=%0d required res=7f co=1 ov=1 lat=%0d",
               r, co, ov, lat, W);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
